sdram_arbiter: RTL and testbench

Two-master arbiter in front of the `sdram` controller port.
- Master 0 is the CPU data bus, in the `16'h4c00`-and-above window of the top-level memory switch.
- Master 1 is a second requester, such as a DMA or blitter engine.
- The block serialises their accesses into single-command transactions, with round-robin fairness and a completion timeout.
- It runs entirely on the board clock `clki`. Masters in other clock domains must be synchronised outside this block.

---
 rtl/sdram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master round-robin arbiter in front of the sdram controller port
//
// Serialises single-command read/write transactions from two masters onto one
// sdram controller port, with round-robin tie-breaking and a completion timeout.
//
// Ports:
//   clki, rst                      clock and synchronous active-high reset
//   mN_addr/wdata/read/write       master N request (level, held until mN_ready)
//   mN_rdata                       master N read data, updated only on its own completion
//   mN_busy                        master N request pending and not completing this cycle
//   mN_ready, mN_err               one-cycle completion pulse, err set when timed out
//   s_addr, s_wdata                command address/data, stable from ISSUE through DONE
//   s_read, s_write                one-cycle command strobes
//   s_rdata, s_busy, s_ready       sdram controller response side
module sdram_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clki,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_read,
    input  logic          m0_write,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_busy,
    output logic          m0_ready,
    output logic          m0_err,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_read,
    input  logic          m1_write,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_busy,
    output logic          m1_ready,
    output logic          m1_err,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_read,
    output logic          s_write,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_busy,
    input  logic          s_ready
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;      // master owning the current transaction
    logic          last_q, last_d;    // master granted most recently
    logic          is_wr_q, is_wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic          s_read_q, s_read_d;
    logic          s_write_q, s_write_d;
    logic          m0_ready_q, m0_ready_d;
    logic          m1_ready_q, m1_ready_d;
    logic          m0_err_q, m0_err_d;
    logic          m1_err_q, m1_err_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic req0, req1, sel, sel_wr;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On a tie the master that did not win last time is chosen.
    assign sel    = (req0 & req1) ? ~last_q : req1;
    assign sel_wr = sel ? m1_write : m0_write;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_read_d   = 1'b0;
        s_write_d  = 1'b0;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if ((req0 | req1) && !s_busy) begin
                    gnt_d     = sel;
                    last_d    = sel;
                    is_wr_d   = sel_wr;
                    s_addr_d  = sel ? m1_addr : m0_addr;
                    s_wdata_d = sel ? m1_wdata : m0_wdata;
                    // Strobes are registered so they appear exactly in the ISSUE cycle.
                    s_write_d = sel_wr;
                    s_read_d  = ~sel_wr;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response in the final counted cycle still wins over the timeout.
                if (s_ready) begin
                    if (!is_wr_q) begin
                        if (gnt_q) m1_rdata_d = s_rdata;
                        else       m0_rdata_d = s_rdata;
                    end
                    m0_ready_d = ~gnt_q;
                    m1_ready_d = gnt_q;
                    state_d    = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    if (gnt_q) m1_rdata_d = '0;
                    else       m0_rdata_d = '0;
                    m0_ready_d = ~gnt_q;
                    m1_ready_d = gnt_q;
                    m0_err_d   = ~gnt_q;
                    m1_err_d   = gnt_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            is_wr_q    <= 1'b0;
            cnt_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_read_q   <= 1'b0;
            s_write_q  <= 1'b0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_read_q   <= s_read_d;
            s_write_q  <= s_write_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_read   = s_read_q;
    assign s_write  = s_write_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

    // Busy is combinational so it also covers the wait-for-grant period.
    assign m0_busy = req0 & ~m0_ready_q;
    assign m1_busy = req1 & ~m1_ready_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard testbench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int TMO = 8;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic        clki = 1'b0;
    logic        rst;
    logic [23:0] m_addr [2];
    logic [15:0] m_wdata [2];
    logic [1:0]  m_read, m_write;
    logic [15:0] m0_rdata, m1_rdata;
    logic [1:0]  m_busy, m_ready, m_err;
    logic [23:0] s_addr;
    logic [15:0] s_wdata, s_rdata;
    logic        s_read, s_write, s_busy, s_ready;

    int          checks = 0;
    int          errors = 0;
    bit          slave_auto;
    bit          rand_busy;
    logic [15:0] last_rd [2];
    exp_t        eq0[$], eq1[$];
    int          gq[$];
    logic [23:0] gaq[$];

    sdram_arbiter #(.AW(24), .DW(16), .TIMEOUT(TMO)) dut (
        .clki(clki), .rst(rst),
        .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
        .m0_rdata(m0_rdata), .m0_busy(m_busy[0]), .m0_ready(m_ready[0]), .m0_err(m_err[0]),
        .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
        .m1_rdata(m1_rdata), .m1_busy(m_busy[1]), .m1_ready(m_ready[1]), .m1_err(m_err[1]),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
        .s_rdata(s_rdata), .s_busy(s_busy), .s_ready(s_ready)
    );

    initial forever #5 clki = ~clki;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rules: timed-out access reads back 0, a write leaves rdata alone,
    // a read returns the slave pattern for that address.
    task automatic start_req(input int n, input bit rd, input bit wr,
                             input logic [23:0] a, input logic [15:0] d);
        exp_t e;
        logic [15:0] v;
        if (a[23])   v = 16'h0;
        else if (wr) v = last_rd[n];
        else         v = a[15:0] ^ 16'hBEFF;
        last_rd[n] = v;
        e.err   = a[23];
        e.rdata = v;
        if (n == 0) eq0.push_back(e);
        else        eq1.push_back(e);
        m_addr[n]  = a;
        m_wdata[n] = d;
        m_read[n]  = rd;
        m_write[n] = wr;
    endtask

    task automatic finish_req(input int n, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clki);
            if (m_ready[n]) begin
                got = 1;
                break;
            end
            cyc++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready wait m%0d: got no ready, expected ready within 400 cycles", n);
        end
        @(posedge clki);
        #1;
        m_read[n]  = 1'b0;
        m_write[n] = 1'b0;
    endtask

    task automatic do_txn(input int n, input bit rd, input bit wr,
                          input logic [23:0] a, input logic [15:0] d, output int cyc);
        start_req(n, rd, wr, a, d);
        finish_req(n, cyc);
    endtask

    task automatic check_reset_outputs();
        check("rst s_read", s_read, 0);
        check("rst s_write", s_write, 0);
        check("rst s_addr", s_addr, 0);
        check("rst s_wdata", s_wdata, 0);
        check("rst m_ready", m_ready, 0);
        check("rst m_err", m_err, 0);
        check("rst m0_rdata", m0_rdata, 0);
        check("rst m1_rdata", m1_rdata, 0);
    endtask

    // Behavioural slave: latency addr[2:0]+1 cycles after the strobe, never
    // answers when addr[23] is set.
    initial begin
        logic [23:0] a;
        bit          was_rd;
        s_ready = 1'b0;
        s_rdata = 16'h0;
        forever begin
            @(negedge clki);
            if (slave_auto && !rst && (s_read || s_write) && !s_addr[23]) begin
                a      = s_addr;
                was_rd = s_read;
                repeat (int'(a[2:0]) + 1) @(posedge clki);
                #1;
                s_ready = 1'b1;
                s_rdata = was_rd ? (a[15:0] ^ 16'hBEFF) : 16'($urandom);
                @(posedge clki);
                #1;
                s_ready = 1'b0;
                s_rdata = 16'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clki);
        #1;
        if (rand_busy) s_busy = ($urandom_range(0, 3) == 0);
    end

    // Command-side monitor: reference arbitration from the requests seen in the
    // preceding (IDLE) cycle, then expected grant order into gq.
    initial begin
        logic [1:0] req_prev;
        bit         busy_prev, strobe_prev, last_m;
        int         w;
        last_m = 1; req_prev = 0; busy_prev = 0; strobe_prev = 0;
        forever begin
            @(negedge clki);
            if (rst) begin
                last_m = 1;
                gq.delete();
                gaq.delete();
            end else if (s_read || s_write) begin
                check("strobe overlap", s_read & s_write, 0);
                check("strobe width", strobe_prev, 0);
                check("strobe while s_busy", busy_prev, 0);
                check("request before strobe", req_prev != 2'b00, 1);
                if (req_prev != 2'b00) begin
                    w = (req_prev == 2'b11) ? int'(!last_m) : (req_prev[1] ? 1 : 0);
                    last_m = w[0];
                    check("grant addr", s_addr, m_addr[w]);
                    check("grant direction", s_write, m_write[w]);
                    if (m_write[w]) check("grant wdata", s_wdata, m_wdata[w]);
                    gq.push_back(w);
                    gaq.push_back(m_addr[w]);
                end
            end
            req_prev    = {m_read[1] | m_write[1], m_read[0] | m_write[0]};
            busy_prev   = s_busy;
            strobe_prev = s_read | s_write;
        end
    end

    // Completion monitor: pops the scoreboard on every ready pulse.
    initial forever begin
        exp_t        e;
        int          have;
        logic [15:0] r;
        @(negedge clki);
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                r = (n == 1) ? m1_rdata : m0_rdata;
                check("busy", m_busy[n], (m_read[n] | m_write[n]) & ~m_ready[n]);
                if (m_ready[n]) begin
                    check("ready grant order", (gq.size() != 0) ? gq[0] : 9, n);
                    if (gq.size() != 0) begin
                        void'(gq.pop_front());
                        check("s_addr held", s_addr, gaq.pop_front());
                    end
                    have = (n == 1) ? eq1.size() : eq0.size();
                    check("ready has request", have != 0, 1);
                    if (have != 0) begin
                        e = (n == 1) ? eq1.pop_front() : eq0.pop_front();
                        check("err pulse", m_err[n], e.err);
                        check("rdata", r, e.rdata);
                    end
                end else begin
                    check("err without ready", m_err[n], 0);
                end
            end
        end
    end

    initial begin
        int cyc, nstrobe, found, nready;
        bit r0, w0;
        rst = 1'b1;
        s_busy = 1'b0;
        slave_auto = 1; rand_busy = 0;
        m_read = 0; m_write = 0;
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = 0; m_wdata[n] = 0; last_rd[n] = 0;
        end
        repeat (3) @(posedge clki);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Contention out of reset, then back-to-back double requests.
        fork
            begin
                do_txn(0, 0, 1, 24'h000020, 16'h1234, cyc);
                for (int i = 0; i < 4; i++) do_txn(0, 1, 0, 24'h000100 + 24'(i * 8), 16'h0, cyc);
            end
            begin
                do_txn(1, 1, 0, 24'h000040, 16'h0, cyc);
                for (int i = 0; i < 4; i++) do_txn(1, 0, 1, 24'h000200 + 24'(i * 8), 16'(i), cyc);
            end
        join
        repeat (2) @(posedge clki);
        #1;

        // Single read, minimum latency.
        do_txn(0, 1, 0, 24'h000010, 16'h0, cyc);
        check("single read latency", cyc, 3);
        check("single read data", m0_rdata, 16'hBEEF);

        // Read+write conflict: write must win.
        do_txn(0, 1, 1, 24'h000031, 16'h7777, cyc);
        check("rw conflict latency", cyc, 4);

        // Timeout with a late response afterwards.
        do_txn(0, 1, 0, 24'h800018, 16'h0, cyc);
        check("timeout latency", cyc, TMO + 2);
        check("timeout rdata", m0_rdata, 0);
        repeat (2) @(posedge clki);
        #1;
        s_ready = 1'b1;
        s_rdata = 16'hDEAD;
        @(posedge clki);
        #1;
        s_ready = 1'b0;
        nready = 0;
        repeat (4) begin
            @(negedge clki);
            if (m_ready != 0 || s_read || s_write) nready++;
        end
        check("late s_ready ignored", nready, 0);
        @(posedge clki);
        #1;
        do_txn(0, 1, 0, 24'h000060, 16'h0, cyc);
        check("after timeout latency", cyc, 3);

        // s_busy stall on an m1 write.
        s_busy = 1'b1;
        start_req(1, 0, 1, 24'h000048, 16'h5555);
        nstrobe = 0;
        repeat (10) begin
            @(negedge clki);
            if (s_read || s_write) nstrobe++;
        end
        check("busy stall strobes", nstrobe, 0);
        @(posedge clki);
        #1;
        s_busy = 1'b0;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clki);
            if (s_write) begin
                found = i;
                break;
            end
        end
        check("busy release strobe cycle", found, 1);
        finish_req(1, cyc);

        // Reset in WAIT.
        slave_auto = 0;
        m_addr[1] = 24'h000050;
        m_read[1] = 1'b1;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clki);
            if (s_read) begin
                found = i;
                break;
            end
        end
        check("reset test strobe", found, 1);
        @(posedge clki);
        #1;
        rst = 1'b1;
        m_read[1] = 1'b0;
        eq0.delete(); eq1.delete();
        last_rd[0] = 0; last_rd[1] = 0;
        @(posedge clki);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        slave_auto = 1;
        do_txn(1, 1, 0, 24'h000058, 16'h0, cyc);
        check("post-reset read latency", cyc, 3);
        check("post-reset read data", m1_rdata, 16'h0058 ^ 16'hBEFF);

        // Randomised traffic with random s_busy and occasional timeouts.
        rand_busy = 1;
        fork
            for (int i = 0; i < 40; i++) begin
                int k;
                k = $urandom_range(0, 2);
                r0 = (k != 1); w0 = (k != 0);
                repeat ($urandom_range(0, 3)) begin @(posedge clki); #1; end
                do_txn(0, r0, w0, {($urandom_range(0, 7) == 0), 23'($urandom)}, 16'($urandom), cyc);
            end
            for (int i = 0; i < 40; i++) begin
                int k;
                bit r1, w1;
                k = $urandom_range(0, 2);
                r1 = (k != 1); w1 = (k != 0);
                repeat ($urandom_range(0, 3)) begin @(posedge clki); #1; end
                do_txn(1, r1, w1, {($urandom_range(0, 7) == 0), 23'($urandom)}, 16'($urandom), cyc);
            end
        join
        rand_busy = 0;
        s_busy = 1'b0;
        repeat (4) @(posedge clki);
        check("scoreboard drained", eq0.size() + eq1.size() + gq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
